scansione_video: RTL and testbench

Raster scan generator for the 1280×1024 video path. It produces the pixel coordinates `X_CONTROLLO`/`Y_CONTROLLO` that drive the shape hit-test blocks. It also takes back the colour those blocks compute and emits it, blanked and aligned with `HSYNC`/`VSYNC`, toward the DAC. It sits between the pixel clock domain root and the video connector, upstream of all shape/object logic.

---
 rtl/pkg_video.sv | 36 +++
 rtl/linea_ritardo.sv | 36 +++
 rtl/scansione_video.sv | 112 +++++++++++
 tb/tb_scansione_video.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pkg_video.sv
// Shared timing constants and data types for the 1280x1024@60 raster path.
package pkg_video;

  localparam int COORD_W = 11;
  localparam int RGB_W   = 12;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [RGB_W-1:0]   rgb_t;

  // 1280x1024@60, 108 MHz pixel clock
  localparam int H_ATT_D  = 1280;
  localparam int H_FP_D   = 48;
  localparam int H_SYNC_D = 112;
  localparam int H_BP_D   = 248;
  localparam int V_ATT_D  = 1024;
  localparam int V_FP_D   = 1;
  localparam int V_SYNC_D = 3;
  localparam int V_BP_D   = 38;

  localparam int H_TOT_D = H_ATT_D + H_FP_D + H_SYNC_D + H_BP_D;
  localparam int V_TOT_D = V_ATT_D + V_FP_D + V_SYNC_D + V_BP_D;

  localparam int LATENZA_MAX = 7;

  // Per-pixel control bits carried through the alignment delay line.
  typedef struct packed {
    logic attivo;
    logic hs;
    logic vs;
  } raster_t;

  function automatic logic in_window(input coord_t v, input coord_t lo, input coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/linea_ritardo.sv
// Enable-gated shift register of DEPTH stages (0 = wire) with asynchronous active-low clear.
module linea_ritardo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] dato,
  output logic [WIDTH-1:0] ritardato
);

  if (DEPTH < 0 || DEPTH > 7) begin : g_bad_depth
    $error("linea_ritardo: DEPTH must be 0..7");
  end

  if (DEPTH == 0) begin : g_pass
    logic unused_ctrl;
    assign unused_ctrl = ^{clk, rst_n, en};
    assign ritardato   = dato;
  end else begin : g_shift
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else if (en) begin
        stage_q[0] <= dato;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign ritardato = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/scansione_video.sv
// Raster scan generator: pixel coordinates for the hit-test logic, blanked colour and syncs to the DAC.
module scansione_video
  import pkg_video::*;
#(
  parameter int H_ATT    = H_ATT_D,
  parameter int H_FP     = H_FP_D,
  parameter int H_SYNC   = H_SYNC_D,
  parameter int H_BP     = H_BP_D,
  parameter int V_ATT    = V_ATT_D,
  parameter int V_FP     = V_FP_D,
  parameter int V_SYNC   = V_SYNC_D,
  parameter int V_BP     = V_BP_D,
  parameter int SYNC_POL = 1,
  parameter int LATENZA  = 1
) (
  input  logic   CLOCK,
  input  logic   RESET_N,
  input  logic   PIXEL_EN,
  output coord_t X_CONTROLLO,
  output coord_t Y_CONTROLLO,
  output logic   ATTIVO,
  output logic   FINE_QUADRO,
  input  rgb_t   RGB_IN,
  output rgb_t   RGB_OUT,
  output logic   HSYNC,
  output logic   VSYNC
);

  localparam int H_TOT = H_ATT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ATT + V_FP + V_SYNC + V_BP;

  if (H_TOT > 2047 || V_TOT > 2047) begin : g_bad_tot
    $error("scansione_video: line/frame totals exceed 11-bit range");
  end
  if (LATENZA < 0 || LATENZA > LATENZA_MAX) begin : g_bad_lat
    $error("scansione_video: LATENZA must be 0..7");
  end

  localparam coord_t H_ULT  = coord_t'(H_TOT - 1);
  localparam coord_t V_ULT  = coord_t'(V_TOT - 1);
  localparam coord_t H_VIS  = coord_t'(H_ATT);
  localparam coord_t V_VIS  = coord_t'(V_ATT);
  localparam coord_t HS_INI = coord_t'(H_ATT + H_FP);
  localparam coord_t HS_FIN = coord_t'(H_ATT + H_FP + H_SYNC - 1);
  localparam coord_t VS_INI = coord_t'(V_ATT + V_FP);
  localparam coord_t VS_FIN = coord_t'(V_ATT + V_FP + V_SYNC - 1);
  localparam logic   POL    = (SYNC_POL != 0);

  coord_t  x_p0, y_p0;
  logic    x_fine, y_fine;
  raster_t raw_p0, dly_p1;
  logic    fq_p1;
  rgb_t    rgb_p2;
  logic    hs_p2, vs_p2;

  // ---- stage 0: raster counters ----
  assign x_fine = (x_p0 == H_ULT);
  assign y_fine = (y_p0 == V_ULT);

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      x_p0  <= '0;
      y_p0  <= '0;
      fq_p1 <= 1'b0;
    end else begin
      // Only a real wrap pulses, so the post-reset (0,0) never does.
      fq_p1 <= PIXEL_EN & x_fine & y_fine;
      if (PIXEL_EN) begin
        x_p0 <= x_fine ? '0 : x_p0 + coord_t'(1);
        if (x_fine) y_p0 <= y_fine ? '0 : y_p0 + coord_t'(1);
      end
    end
  end

  assign raw_p0.attivo = (x_p0 < H_VIS) && (y_p0 < V_VIS);
  assign raw_p0.hs     = in_window(x_p0, HS_INI, HS_FIN);
  assign raw_p0.vs     = in_window(y_p0, VS_INI, VS_FIN);

  // ---- stage 1: align control bits with the colour returned by the pixel logic ----
  linea_ritardo #(
    .WIDTH ($bits(raster_t)),
    .DEPTH (LATENZA)
  ) u_ritardo (
    .clk       (CLOCK),
    .rst_n     (RESET_N),
    .en        (PIXEL_EN),
    .dato      (raw_p0),
    .ritardato (dly_p1)
  );

  // ---- stage 2: blanking and sync polarity, output register ----
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      rgb_p2 <= '0;
      hs_p2  <= ~POL;
      vs_p2  <= ~POL;
    end else if (PIXEL_EN) begin
      rgb_p2 <= dly_p1.attivo ? RGB_IN : '0;
      hs_p2  <= dly_p1.hs ~^ POL;
      vs_p2  <= dly_p1.vs ~^ POL;
    end
  end

  assign X_CONTROLLO = x_p0;
  assign Y_CONTROLLO = y_p0;
  assign ATTIVO      = raw_p0.attivo;
  assign FINE_QUADRO = fq_p1;
  assign RGB_OUT     = rgb_p2;
  assign HSYNC       = hs_p2;
  assign VSYNC       = vs_p2;

endmodule

// File: tb/tb_scansione_video.sv
// Bench for scansione_video: four instances (small and full timings) against a raster model driven by the enabled-cycle count.
`timescale 1ns/1ps
module tb_scansione_video;

  typedef struct packed {
    int ha; int hf; int hs; int hb;
    int va; int vf; int vs; int vb;
    int pol; int lat;
  } cfg_t;

  localparam cfg_t CA = '{ha:20, hf:3, hs:4, hb:5, va:10, vf:1, vs:2, vb:3, pol:1, lat:1};
  localparam cfg_t CB = '{ha:20, hf:3, hs:4, hb:5, va:10, vf:1, vs:2, vb:3, pol:0, lat:0};
  localparam cfg_t CC = '{ha:16, hf:2, hs:3, hb:4, va:6,  vf:1, vs:2, vb:2, pol:1, lat:7};
  localparam cfg_t CD = '{ha:1280, hf:48, hs:112, hb:248, va:1024, vf:1, vs:3, vb:38, pol:1, lat:1};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [11:0] rgb_in;

  logic [10:0] x_a, y_a, x_b, y_b, x_c, y_c, x_d, y_d;
  logic        att_a, att_b, att_c, att_d;
  logic        fq_a, fq_b, fq_c, fq_d;
  logic [11:0] rgb_a, rgb_b, rgb_c, rgb_d;
  logic        hs_a, hs_b, hs_c, hs_d;
  logic        vs_a, vs_b, vs_c, vs_d;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  scansione_video #(.H_ATT(CA.ha), .H_FP(CA.hf), .H_SYNC(CA.hs), .H_BP(CA.hb),
    .V_ATT(CA.va), .V_FP(CA.vf), .V_SYNC(CA.vs), .V_BP(CA.vb), .SYNC_POL(CA.pol), .LATENZA(CA.lat))
  dut_a (.CLOCK(clk), .RESET_N(rst_n), .PIXEL_EN(en), .X_CONTROLLO(x_a), .Y_CONTROLLO(y_a),
    .ATTIVO(att_a), .FINE_QUADRO(fq_a), .RGB_IN(rgb_in), .RGB_OUT(rgb_a), .HSYNC(hs_a), .VSYNC(vs_a));

  scansione_video #(.H_ATT(CB.ha), .H_FP(CB.hf), .H_SYNC(CB.hs), .H_BP(CB.hb),
    .V_ATT(CB.va), .V_FP(CB.vf), .V_SYNC(CB.vs), .V_BP(CB.vb), .SYNC_POL(CB.pol), .LATENZA(CB.lat))
  dut_b (.CLOCK(clk), .RESET_N(rst_n), .PIXEL_EN(en), .X_CONTROLLO(x_b), .Y_CONTROLLO(y_b),
    .ATTIVO(att_b), .FINE_QUADRO(fq_b), .RGB_IN(rgb_in), .RGB_OUT(rgb_b), .HSYNC(hs_b), .VSYNC(vs_b));

  scansione_video #(.H_ATT(CC.ha), .H_FP(CC.hf), .H_SYNC(CC.hs), .H_BP(CC.hb),
    .V_ATT(CC.va), .V_FP(CC.vf), .V_SYNC(CC.vs), .V_BP(CC.vb), .SYNC_POL(CC.pol), .LATENZA(CC.lat))
  dut_c (.CLOCK(clk), .RESET_N(rst_n), .PIXEL_EN(en), .X_CONTROLLO(x_c), .Y_CONTROLLO(y_c),
    .ATTIVO(att_c), .FINE_QUADRO(fq_c), .RGB_IN(rgb_in), .RGB_OUT(rgb_c), .HSYNC(hs_c), .VSYNC(vs_c));

  scansione_video dut_d (.CLOCK(clk), .RESET_N(rst_n), .PIXEL_EN(en), .X_CONTROLLO(x_d), .Y_CONTROLLO(y_d),
    .ATTIVO(att_d), .FINE_QUADRO(fq_d), .RGB_IN(rgb_in), .RGB_OUT(rgb_d), .HSYNC(hs_d), .VSYNC(vs_d));

  // Model state: number of enabled edges since reset, whether the last edge was enabled,
  // and the colour presented on every enabled edge.
  int          n = 0;
  bit          last_en = 1'b0;
  logic [11:0] hist [int];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n       = 0;
      last_en = 1'b0;
    end else begin
      last_en = en;
      if (en) begin
        hist[n] = rgb_in;
        n++;
      end
    end
  end

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at t=%0t n=%0d: got=%0h want=%0h", name, $time, n, got, want);
    end
  endtask

  task automatic chk(input string nm, input cfg_t c, input logic [10:0] x, input logic [10:0] y,
                     input logic att, input logic fq, input logic [11:0] rgb,
                     input logic hs, input logic vs);
    int          ht, vt, m, xm, ym, xn, yn;
    logic        pol, hs_e, vs_e, fq_e, att_e;
    logic [11:0] rgb_e;
    ht  = c.ha + c.hf + c.hs + c.hb;
    vt  = c.va + c.vf + c.vs + c.vb;
    pol = (c.pol != 0);
    xn  = n % ht;
    yn  = (n / ht) % vt;
    att_e = (xn < c.ha) && (yn < c.va);
    fq_e  = last_en && (n > 0) && ((n % (ht * vt)) == 0);
    m = n - c.lat - 1;
    if (m < 0) begin
      rgb_e = 12'h000;
      hs_e  = !pol;
      vs_e  = !pol;
    end else begin
      xm    = m % ht;
      ym    = (m / ht) % vt;
      rgb_e = ((xm < c.ha) && (ym < c.va)) ? hist[m + c.lat] : 12'h000;
      hs_e  = ((xm >= c.ha + c.hf) && (xm < c.ha + c.hf + c.hs)) ? pol : !pol;
      vs_e  = ((ym >= c.va + c.vf) && (ym < c.va + c.vf + c.vs)) ? pol : !pol;
    end
    cmp({nm, ".x"},      32'(x),   32'(xn));
    cmp({nm, ".y"},      32'(y),   32'(yn));
    cmp({nm, ".attivo"}, 32'(att), 32'(att_e));
    cmp({nm, ".fine"},   32'(fq),  32'(fq_e));
    cmp({nm, ".rgb"},    32'(rgb), 32'(rgb_e));
    cmp({nm, ".hsync"},  32'(hs),  32'(hs_e));
    cmp({nm, ".vsync"},  32'(vs),  32'(vs_e));
  endtask

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    chk("A", CA, x_a, y_a, att_a, fq_a, rgb_a, hs_a, vs_a);
    chk("B", CB, x_b, y_b, att_b, fq_b, rgb_b, hs_b, vs_b);
    chk("C", CC, x_c, y_c, att_c, fq_c, rgb_c, hs_c, vs_c);
    chk("D", CD, x_d, y_d, att_d, fq_d, rgb_d, hs_d, vs_d);
  end

  task automatic check_reset_values(input string tag);
    cmp({tag, ".D.x"},   32'(x_d),   32'd0);
    cmp({tag, ".D.y"},   32'(y_d),   32'd0);
    cmp({tag, ".D.rgb"}, 32'(rgb_d), 32'd0);
    cmp({tag, ".D.hs"},  32'(hs_d),  32'd0);
    cmp({tag, ".D.vs"},  32'(vs_d),  32'd0);
    cmp({tag, ".A.fq"},  32'(fq_a),  32'd0);
    cmp({tag, ".B.hs"},  32'(hs_b),  32'd1);
    cmp({tag, ".B.vs"},  32'(vs_b),  32'd1);
    cmp({tag, ".C.x"},   32'(x_c),   32'd0);
  endtask

  // Continuous enable from a fresh reset, with hand-computed checkpoints.
  task automatic cont_phase(input int len);
    for (int k = 1; k <= len; k++) begin
      en     = 1'b1;
      rgb_in = 12'($urandom);
      @(negedge clk);
      if (k == 1)    begin cmp("lit.D.x1", 32'(x_d), 32'd1); cmp("lit.D.y1", 32'(y_d), 32'd0); end
      if (k == 23)   cmp("lit.B.hs23", 32'(hs_b), 32'd1);
      if (k == 24)   begin cmp("lit.A.hs24", 32'(hs_a), 32'd0); cmp("lit.B.hs24", 32'(hs_b), 32'd0); end
      if (k == 25)   begin cmp("lit.A.hs25", 32'(hs_a), 32'd1); cmp("lit.C.hs25", 32'(hs_c), 32'd0); end
      if (k == 26)   cmp("lit.C.hs26", 32'(hs_c), 32'd1);
      if (k == 28)   cmp("lit.A.hs28", 32'(hs_a), 32'd1);
      if (k == 29)   cmp("lit.A.hs29", 32'(hs_a), 32'd0);
      if (k == 511)  cmp("lit.A.fq511", 32'(fq_a), 32'd0);
      if (k == 512)  begin
        cmp("lit.A.fq512", 32'(fq_a), 32'd1);
        cmp("lit.A.x512", 32'(x_a), 32'd0);
        cmp("lit.A.y512", 32'(y_a), 32'd0);
      end
      if (k == 513)  cmp("lit.A.fq513", 32'(fq_a), 32'd0);
      if (k == 1329) cmp("lit.D.hs1329", 32'(hs_d), 32'd0);
      if (k == 1330) cmp("lit.D.hs1330", 32'(hs_d), 32'd1);
      if (k == 1435) cmp("lit.D.hs1435", 32'(hs_d), 32'd1);
      if (k == 1688) begin cmp("lit.D.x1688", 32'(x_d), 32'd0); cmp("lit.D.y1688", 32'(y_d), 32'd1); end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    en     = 1'b0;
    rgb_in = 12'h000;
    repeat (3) @(negedge clk);
    check_reset_values("rst0");
    rst_n = 1'b1;

    cont_phase(1435);

    // Reset mid-line while the full-size HSYNC is active: everything clears at once.
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_values("rstmid");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    cont_phase(1800);

    // Alternating enable with a white input.
    for (int k = 0; k < 1200; k++) begin
      en     = k[0];
      rgb_in = 12'hFFF;
      @(negedge clk);
    end

    // Random enable and colour.
    for (int k = 0; k < 3000; k++) begin
      en     = ($urandom_range(0, 3) != 0);
      rgb_in = 12'($urandom);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
